// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: state encoding, requester ids
// and the legal ranges of the timing parameters.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam int RD_LAT_MIN   = 1;
  localparam int RD_LAT_MAX   = 7;
  localparam int MAX_WAIT_MIN = 1;
  localparam int MAX_WAIT_MAX = 15;

  // Counter widths cover the largest legal parameter value.
  localparam int LAT_CNT_W = $clog2(RD_LAT_MAX + 1);
  localparam int STARVE_W  = $clog2(MAX_WAIT_MAX + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection with data priority, bounded by a starvation counter that
// forces a fetch grant after MAX_WAIT consecutive data grants.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    if_req,
  input  logic    d_req,
  input  logic    arb_en,
  output req_id_e winner
);

  localparam logic [STARVE_W-1:0] WAIT_LIM = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;

  always_comb begin
    winner       = REQ_DATA;
    starve_cnt_d = starve_cnt_q;
    if (if_req && (!d_req || starve_cnt_q == WAIT_LIM)) begin
      winner = REQ_FETCH;
    end
    if (arb_en) begin
      // Count only data grants that overtake a waiting fetch.
      if (winner == REQ_FETCH || !if_req) begin
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-transaction arbiter sharing one synchronous RAM port between
// instruction fetch and data access; all outputs decode from registers.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

  arb_state_e           state_q, state_d;
  req_id_e              id_q, id_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;

  logic    arb_en;
  req_id_e winner;

  assign arb_en = (state_q == IDLE || state_q == RESP) && (if_req || d_req);

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .arb_en (arb_en),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (arb_en) begin
          id_d    = winner;
          state_d = ISSUE;
          if (winner == REQ_FETCH) begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end else begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= REQ_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_gnt    = (state_q == ISSUE) && (id_q == REQ_FETCH);
  assign d_gnt     = (state_q == ISSUE) && (id_q == REQ_DATA);
  assign if_rvalid = (state_q == RESP) && (id_q == REQ_FETCH);
  assign d_rvalid  = (state_q == RESP) && (id_q == REQ_DATA);
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A (RD_LAT=1, MAX_WAIT=2) with a RAM model,
// instance B (RD_LAT=3) fed a cycle-stamped mem_rdata to pin read timing.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // Instance A signals
  logic        if_req_a, d_req_a, d_we_a;
  logic [7:0]  if_addr_a, d_addr_a, mem_addr_a;
  logic [15:0] d_wdata_a, rdata_a, mem_wdata_a, mem_rdata_a;
  logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a, busy_a;

  // Instance B signals
  logic        if_req_b, d_req_b, d_we_b;
  logic [7:0]  if_addr_b, d_addr_b, mem_addr_b;
  logic [15:0] d_wdata_b, rdata_b, mem_wdata_b, mem_rdata_b;
  logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, busy_b;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .MAX_WAIT(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .rdata(rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .MAX_WAIT(2)) u_dut_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .rdata(rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // RAM model for A: one-cycle registered read, write in the mem_en cycle.
  logic [15:0] ram [0:255];
  logic [15:0] ram_rd_q = 16'h0;
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      ram[8'h10] <= 16'hABCD;
      ram_ready  <= 1'b1;
    end else if (mem_en_a) begin
      if (mem_we_a) ram[mem_addr_a] <= mem_wdata_a;
      else          ram_rd_q <= ram[mem_addr_a];
    end
  end
  assign mem_rdata_a = ram_rd_q;

  // B's read data carries the cycle number, so the sampled value reveals when it was taken.
  assign mem_rdata_b = {8'hC0, cyc[7:0]};

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fetch_read(input logic [7:0] addr, input logic [15:0] exp);
    if_req_a = 1'b1; if_addr_a = addr;
    @(negedge clk);
    check_eq("fetch_if_gnt", if_gnt_a, 1);
    check_eq("fetch_mem_en", mem_en_a, 1);
    check_eq("fetch_mem_addr", mem_addr_a, addr);
    check_eq("fetch_mem_we", mem_we_a, 0);
    if_req_a = 1'b0;
    @(negedge clk);
    check_eq("fetch_wait_busy", busy_a, 1);
    check_eq("fetch_wait_rvalid", if_rvalid_a, 0);
    @(negedge clk);
    check_eq("fetch_if_rvalid", if_rvalid_a, 1);
    check_eq("fetch_rdata", rdata_a, exp);
    check_eq("fetch_d_rvalid", d_rvalid_a, 0);
    @(negedge clk);
    check_eq("fetch_idle_busy", busy_a, 0);
    check_eq("fetch_idle_rvalid", if_rvalid_a, 0);
    $display("[TB] fetch addr=0x%0h data=0x%0h", addr, rdata_a);
  endtask

  logic [1:0]  exp2;
  int          extra, spurious, lat, found, t0;
  logic [15:0] rd_b;

  initial begin
    reset = 1'b0;
    if_req_a = 0; if_addr_a = 0; d_req_a = 0; d_we_a = 0; d_addr_a = 0; d_wdata_a = 0;
    if_req_b = 0; if_addr_b = 0; d_req_b = 0; d_we_b = 0; d_addr_b = 0; d_wdata_b = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_mem_en", mem_en_a, 0);
    check_eq("rst_rdata", rdata_a, 0);
    check_eq("rst_busy_b", busy_b, 0);
    reset = 1'b1;
    @(negedge clk);

    // Fetch read of preloaded word.
    fetch_read(8'h10, 16'hABCD);

    // Data write, then fetch it back.
    d_req_a = 1; d_we_a = 1; d_addr_a = 8'h05; d_wdata_a = 16'h1234;
    @(negedge clk);
    check_eq("wr_d_gnt", d_gnt_a, 1);
    check_eq("wr_mem_we", mem_we_a, 1);
    check_eq("wr_mem_wdata", mem_wdata_a, 16'h1234);
    check_eq("wr_mem_addr", mem_addr_a, 8'h05);
    d_req_a = 0; d_we_a = 0;
    @(negedge clk);
    check_eq("wr_busy_after", busy_a, 0);
    check_eq("wr_no_rvalid", {if_rvalid_a, d_rvalid_a}, 0);
    $display("[TB] write addr=0x05 data=0x1234");
    fetch_read(8'h05, 16'h1234);

    // Simultaneous requests: data first, fetch via RESP->ISSUE.
    if_req_a = 1; if_addr_a = 8'h10; d_req_a = 1; d_we_a = 0; d_addr_a = 8'h05;
    @(negedge clk);
    check_eq("sim_gnt_first", {if_gnt_a, d_gnt_a}, 2'b01);
    d_req_a = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("sim_d_rvalid", d_rvalid_a, 1);
    check_eq("sim_d_rdata", rdata_a, 16'h1234);
    check_eq("sim_if_gnt_early", if_gnt_a, 0);
    @(negedge clk);
    check_eq("sim_gnt_second", {if_gnt_a, d_gnt_a}, 2'b10);
    check_eq("sim_mem_addr", mem_addr_a, 8'h10);
    if_req_a = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("sim_if_rvalid", if_rvalid_a, 1);
    check_eq("sim_if_rdata", rdata_a, 16'hABCD);
    @(negedge clk);
    $display("[TB] simultaneous data-then-fetch done");

    // Both held high: grants at cycles 1,4,..,16 in order D,D,F,D,D,F.
    if_req_a = 1; d_req_a = 1; d_we_a = 0; d_addr_a = 8'h05; if_addr_a = 8'h10;
    extra = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k % 3 == 1) begin
        exp2 = (k == 7 || k == 16) ? 2'b10 : 2'b01;
        check_eq($sformatf("hold_gnt_c%0d", k), {if_gnt_a, d_gnt_a}, exp2);
      end else if (if_gnt_a || d_gnt_a) begin
        extra++;
      end
      if (k % 3 == 0) begin
        exp2 = (k - 2 == 7 || k - 2 == 16) ? 2'b10 : 2'b01;
        check_eq($sformatf("hold_rvalid_c%0d", k), {if_rvalid_a, d_rvalid_a}, exp2);
      end
      if (k == 16) begin if_req_a = 0; d_req_a = 0; end
    end
    check_eq("hold_extra_gnt", extra, 0);
    @(negedge clk);
    check_eq("hold_idle_busy", busy_a, 0);
    $display("[TB] held requests grant order D,D,F,D,D,F checked");

    // RD_LAT=3 on instance B.
    t0 = int'(cyc);
    if_req_b = 1; if_addr_b = 8'h22;
    @(negedge clk);
    check_eq("lat3_gnt", if_gnt_b, 1);
    check_eq("lat3_mem_addr", mem_addr_b, 8'h22);
    if_req_b = 0;
    found = 0; lat = 0; rd_b = 0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (found == 0 && if_rvalid_b) begin found = 1; lat = k; rd_b = rdata_b; end
    end
    check_eq("lat3_rvalid_seen", found, 1);
    check_eq("lat3_gnt_to_rvalid", lat - 1, 4);
    check_eq("lat3_rdata", rd_b, {8'hC0, 8'(t0 + 4)});
    check_eq("lat3_idle_busy", busy_b, 0);
    $display("[TB] lat3 fetch addr=0x22 data=0x%0h", rd_b);

    // Reset asserted during WAIT drops the transaction.
    if_req_a = 1; if_addr_a = 8'h10;
    @(negedge clk);
    check_eq("rstw_gnt", if_gnt_a, 1);
    @(negedge clk);
    check_eq("rstw_wait_busy", busy_a, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("rstw_busy", busy_a, 0);
    check_eq("rstw_mem_en", mem_en_a, 0);
    check_eq("rstw_rdata", rdata_a, 0);
    check_eq("rstw_rvalid", if_rvalid_a, 0);
    spurious = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_gnt_a || if_rvalid_a || busy_a || mem_en_a) spurious++;
    end
    if_req_a = 0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_rvalid_a || busy_a) spurious++;
    end
    check_eq("rstw_no_activity", spurious, 0);
    $display("[TB] reset during WAIT dropped transaction");
    fetch_read(8'h05, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single-port synchronous RAM between two requesters: instruction fetch (driven by the fetch/IL phase of the control logic) and data access (LW/SW in the execute phase). Only one transaction is in flight at a time. The block arbitrates with data priority plus a starvation guard for fetch, issues the RAM access, counts RAM read latency, and returns read data with a one-cycle valid pulse. It sits between the control logic/datapath and the RAM, and exposes busy for stall generation.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 16, RAM word width
RD_LAT, 1, RAM read latency in cycles from the mem_en cycle to valid mem_rdata; legal range is 1..7
MAX_WAIT, 2, maximum consecutive data grants while a fetch request is pending; legal range is 1..15

Ports:
clk  in  1  single clock, all state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 resets the block immediately
if_req  in  1  fetch read request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted and issued
if_rvalid  out  1  one-cycle pulse: rdata holds the fetch result
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = write (SW), 0 = read (LW)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  one-cycle pulse: data request accepted and issued
d_rvalid  out  1  one-cycle pulse on data reads only
rdata  out  DATA_W  registered read data shared by both requesters; meaningful only while a rvalid is high
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, starvation count=0, latched request and rdata cleared to 0. All outputs are 0. Any in-flight transaction is dropped and no rvalid is produced for it. Requests are ignored while reset is low.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are decoded from registered state or latched fields. There are no combinational paths from req to gnt or mem_*.
- Arbitration happens at the clock edge in IDLE or RESP when any req=1:
  - Fetch wins if d_req=0, or if the starvation count equals MAX_WAIT.
  - Otherwise data wins.
  - The winner's id, addr, we and wdata are latched (fetch is latched with we=0), and the next state is ISSUE.
  - If no req is present, IDLE→IDLE and RESP→IDLE.
- Starvation count:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant.
  - Also clears on a data grant while if_req=0.
  - Never exceeds MAX_WAIT.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latch.
  - The winner's gnt=1.
  - On a write, next state is IDLE: no rvalid, and the write completes in the ISSUE cycle.
  - On a read, next state is WAIT.
- WAIT lasts exactly RD_LAT cycles, counted by an internal counter. On its final edge, rdata is loaded from mem_rdata. Next state is RESP.
- RESP (1 cycle): rvalid=1 for the latched id; rdata is stable.
- Read latency: with the ISSUE cycle at T, rvalid is asserted at T+RD_LAT+1.
- Back-to-back throughput:
  - Read: ISSUE at T, next ISSUE earliest at T+RD_LAT+2.
  - Write: ISSUE at T, next ISSUE earliest at T+2.
- Requester rules:
  - req, addr, we and wdata must be stable from req assertion through the gnt cycle.
  - req must drop in the cycle after gnt unless a new request is intended.
  - Input changes after latching are ignored.
- Simultaneous requests with count < MAX_WAIT: data wins and fetch stays pending.
- mem_we=0 and mem_en=0 outside ISSUE.
- busy=1 in ISSUE, WAIT and RESP.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - requester id constants (REQ_FETCH=0, REQ_DATA=1)
  - RD_LAT and MAX_WAIT range limits
- One sub-module, mem_arb_pick, is natural. It contains the starvation counter plus winner selection. Its inputs are the two req lines and the arbitrate strobe; its output is the winner id.

Test Plan:
- Fetch read, RD_LAT=1, RAM[0x10]=0xABCD: if_req with if_addr=0x10 seen at edge of cycle 0 → cycle 1 has mem_en=1, if_gnt=1, mem_addr=0x10 → cycle 3 has if_rvalid=1, rdata=0xABCD; d_rvalid stays 0.
- Data write: d_req, d_we=1, d_addr=0x05, d_wdata=0x1234 → one cycle with mem_en=1, mem_we=1, d_gnt=1; no rvalid; busy returns to 0 the next cycle; a later fetch of 0x05 returns 0x1234.
- Simultaneous if_req and d_req (read) in IDLE, MAX_WAIT=2 → d_gnt first; if_gnt issues in the cycle after d_rvalid's RESP ends, via RESP→ISSUE.
- d_req and if_req held continuously high, MAX_WAIT=2, all reads → grant sequence is D,D,F,D,D,F; count never exceeds 2.
- RD_LAT=3 read → rvalid exactly 4 cycles after the gnt cycle; rdata equals mem_rdata sampled 3 cycles after mem_en.
- reset driven low during WAIT → all outputs 0 immediately, no rvalid ever for that transaction; after release, a new if_req completes normally.
